// File: rtl/fb_row_writer.sv
// Framebuffer row writer: latches one received row (or a fill colour) and
// streams it into the framebuffer write port one pixel per granted cycle.
module fb_row_writer #(
  parameter int PIX_BITS = 3,
  parameter int WIDTH    = 640,
  parameter int HEIGHT   = 480,
  parameter int ADDR_W   = 19,
  parameter int ROW_W    = $clog2(HEIGHT)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      row_valid,
  output logic                      row_ready,
  input  logic [ROW_W-1:0]          row_idx,
  input  logic [PIX_BITS*WIDTH-1:0] row_data,
  input  logic                      fill_req,
  input  logic [PIX_BITS-1:0]       fill_color,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [PIX_BITS-1:0]       mem_wdata,
  input  logic                      mem_gnt,
  output logic                      busy,
  output logic                      row_done,
  output logic                      frame_done,
  output logic                      row_err
);

  localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, WRITE, FILL, DONE} state_t;

  state_t                    state, state_nx;
  logic [PIX_BITS*WIDTH-1:0] shadow;
  logic [PIX_BITS-1:0]       color;
  logic [ADDR_W-1:0]         addr;
  logic [COL_W-1:0]          col;
  logic                      last_row;
  logic                      accept;
  logic                      idx_ok;

  assign row_ready = (state == IDLE) && !fill_req;
  assign accept    = row_valid && row_ready;
  assign idx_ok    = 32'(row_idx) < 32'(HEIGHT);
  assign mem_addr  = addr;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    mem_we    = 1'b0;
    mem_wdata = '0;
    unique case (state)
      IDLE: begin
        if (fill_req)               state_nx = FILL;
        else if (accept && idx_ok)  state_nx = WRITE;
      end
      WRITE: begin
        mem_we    = 1'b1;
        mem_wdata = shadow[col*PIX_BITS +: PIX_BITS];
        if (mem_gnt && col == LAST_COL) state_nx = DONE;
      end
      FILL: begin
        mem_we    = 1'b1;
        mem_wdata = color;
        if (mem_gnt && addr == LAST_ADDR) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Status pulses are set on the edge entering DONE so they coincide with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow     <= '0;
      color      <= '0;
      addr       <= '0;
      col        <= '0;
      last_row   <= 1'b0;
      row_done   <= 1'b0;
      frame_done <= 1'b0;
      row_err    <= 1'b0;
    end else begin
      row_done   <= 1'b0;
      frame_done <= 1'b0;
      row_err    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (fill_req) begin
            color <= fill_color;
            addr  <= '0;
          end else if (accept) begin
            if (idx_ok) begin
              shadow   <= row_data;
              addr     <= ADDR_W'(row_idx) * ADDR_W'(WIDTH);
              col      <= '0;
              last_row <= (32'(row_idx) == 32'(HEIGHT - 1));
            end else begin
              row_err <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (mem_gnt) begin
            col  <= col + 1'b1;
            addr <= addr + 1'b1;
            if (col == LAST_COL) begin
              row_done   <= 1'b1;
              frame_done <= last_row;
            end
          end
        end
        FILL: begin
          if (mem_gnt) begin
            addr <= addr + 1'b1;
            if (addr == LAST_ADDR) frame_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_row_writer.sv
// Directed self-checking bench for fb_row_writer on an 8x4 frame, 3-bit pixels.
module tb_fb_row_writer;

  localparam int PB = 3;
  localparam int W  = 8;
  localparam int H  = 4;
  localparam int AW = 5;
  localparam int RW = 3;
  localparam int DW = PB * W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          row_valid;
  logic          row_ready;
  logic [RW-1:0] row_idx;
  logic [DW-1:0] row_data;
  logic          fill_req;
  logic [PB-1:0] fill_color;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [PB-1:0] mem_wdata;
  logic          mem_gnt;
  logic          busy;
  logic          row_done;
  logic          frame_done;
  logic          row_err;

  int checks = 0;
  int errors = 0;

  logic [PB-1:0] wmem [32];
  int            wcnt [32];
  int            base [32];
  int            rd_cnt = 0;
  int            fd_cnt = 0;
  int            we_cnt = 0;

  fb_row_writer #(
    .PIX_BITS(PB),
    .WIDTH   (W),
    .HEIGHT  (H),
    .ADDR_W  (AW),
    .ROW_W   (RW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .row_idx   (row_idx),
    .row_data  (row_data),
    .fill_req  (fill_req),
    .fill_color(fill_color),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_gnt   (mem_gnt),
    .busy      (busy),
    .row_done  (row_done),
    .frame_done(frame_done),
    .row_err   (row_err)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 32; i++) begin
      wmem[i] = '0;
      wcnt[i] = 0;
    end
  end

  always @(posedge clk) begin
    if (mem_we && mem_gnt) begin
      wmem[mem_addr] <= mem_wdata;
      wcnt[mem_addr] <= wcnt[mem_addr] + 1;
    end
  end

  always @(negedge clk) begin
    if (row_done)   rd_cnt <= rd_cnt + 1;
    if (frame_done) fd_cnt <= fd_cnt + 1;
    if (mem_we)     we_cnt <= we_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Cycle 0: present and accept a packet; returns 1 ns into cycle 1.
  task automatic send_row(input logic [RW-1:0] idx, input logic [DW-1:0] data);
    row_valid = 1'b1;
    row_idx   = idx;
    row_data  = data;
    @(negedge clk);
    chk("accept_ready", 32'(row_ready), 1);
    nxt();
    row_valid = 1'b0;
    row_data  = DW'($urandom());
  endtask

  // Cycles 1..W+2 of a row with grant held high.
  task automatic run_row(input int base_addr, input logic [DW-1:0] data, input logic last);
    for (int c = 0; c < W; c++) begin
      @(negedge clk);
      chk("row_we",    32'(mem_we), 1);
      chk("row_addr",  32'(mem_addr), 32'(base_addr + c));
      chk("row_wdata", 32'(mem_wdata), 32'(data[c*PB +: PB]));
      chk("row_busy",  32'(busy), 1);
      chk("row_done_early", 32'(row_done), 0);
      nxt();
    end
    @(negedge clk);
    chk("row_done",       32'(row_done), 1);
    chk("row_frame_done", 32'(frame_done), 32'(last));
    chk("done_we",        32'(mem_we), 0);
    chk("done_busy",      32'(busy), 1);
    nxt();
    @(negedge clk);
    chk("after_ready",    32'(row_ready), 1);
    chk("after_busy",     32'(busy), 0);
    chk("after_row_done", 32'(row_done), 0);
    chk("after_frame",    32'(frame_done), 0);
    nxt();
  endtask

  logic [DW-1:0] d_a, d_b, d_c, d_d, d_e;
  int            snap, col_m;
  logic          g;
  logic [3:0]    gpat;

  initial begin
    rst_n      = 1'b0;
    row_valid  = 1'b0;
    row_idx    = '0;
    row_data   = '0;
    fill_req   = 1'b0;
    fill_color = '0;
    mem_gnt    = 1'b1;
    for (int c = 0; c < W; c++) begin
      d_a[c*PB +: PB] = PB'(c);
      d_b[c*PB +: PB] = PB'(7 - c);
      d_c[c*PB +: PB] = PB'(3 * c + 1);
      d_d[c*PB +: PB] = PB'(c + 2);
      d_e[c*PB +: PB] = PB'(5 * c + 3);
    end

    // Reset values
    @(negedge clk);
    chk("rst_ready", 32'(row_ready), 1);
    chk("rst_we",    32'(mem_we), 0);
    chk("rst_addr",  32'(mem_addr), 0);
    chk("rst_wdata", 32'(mem_wdata), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_rdone", 32'(row_done), 0);
    chk("rst_fdone", 32'(frame_done), 0);
    chk("rst_err",   32'(row_err), 0);
    #2 rst_n = 1'b1;
    nxt();

    // Row 2, pixels 0..7, not the last row
    send_row(3'd2, d_a);
    run_row(16, d_a, 1'b0);

    // Row 3 is the last row of the frame
    send_row(3'd3, d_b);
    run_row(24, d_b, 1'b1);

    // Out-of-range row index is dropped
    snap = we_cnt;
    send_row(3'd5, d_c);
    @(negedge clk);
    chk("err_pulse", 32'(row_err), 1);
    chk("err_we",    32'(mem_we), 0);
    chk("err_busy",  32'(busy), 0);
    chk("err_ready", 32'(row_ready), 1);
    nxt();
    @(negedge clk);
    chk("err_once",  32'(row_err), 0);
    chk("err_no_we", 32'(we_cnt), 32'(snap));
    nxt();

    // Grant pattern 1,0,0,1 on row 0: 8 grants land on k = 0,3,4,7,8,11,12,15
    for (int i = 0; i < 32; i++) base[i] = wcnt[i];
    gpat = 4'b1001;
    send_row(3'd0, d_c);
    col_m = 0;
    for (int k = 0; k < 16; k++) begin
      g = gpat[3 - (k % 4)];
      mem_gnt = g;
      @(negedge clk);
      chk("stall_we",    32'(mem_we), 1);
      chk("stall_addr",  32'(mem_addr), 32'(col_m));
      chk("stall_wdata", 32'(mem_wdata), 32'(d_c[col_m*PB +: PB]));
      if (g) col_m++;
      nxt();
    end
    mem_gnt = 1'b1;
    @(negedge clk);
    chk("stall_done", 32'(row_done), 1);
    chk("stall_we_off", 32'(mem_we), 0);
    for (int a = 0; a < W; a++) begin
      chk("stall_wcnt", 32'(wcnt[a] - base[a]), 1);
      chk("stall_data", 32'(wmem[a]), 32'(d_c[a*PB +: PB]));
    end
    nxt();
    nxt();

    // Fill with colour 5 wins over a simultaneous row packet
    snap = rd_cnt;
    fill_req   = 1'b1;
    fill_color = 3'd5;
    row_valid  = 1'b1;
    row_idx    = 3'd1;
    row_data   = d_d;
    @(negedge clk);
    chk("fill_ready_low", 32'(row_ready), 0);
    nxt();
    fill_req   = 1'b0;
    fill_color = 3'd2;
    for (int k = 0; k < W * H; k++) begin
      @(negedge clk);
      chk("fill_addr",  32'(mem_addr), 32'(k));
      chk("fill_wdata", 32'(mem_wdata), 5);
      chk("fill_ready", 32'(row_ready), 0);
      nxt();
    end
    @(negedge clk);
    chk("fill_frame_done", 32'(frame_done), 1);
    chk("fill_no_row_done", 32'(row_done), 0);
    for (int a = 0; a < W * H; a++) chk("fill_mem", 32'(wmem[a]), 5);
    nxt();
    @(negedge clk);
    chk("fill_then_ready", 32'(row_ready), 1);
    nxt();
    row_valid = 1'b0;
    row_data  = '0;
    run_row(8, d_d, 1'b0);
    chk("fill_rd_cnt", 32'(rd_cnt - snap), 1);

    // Asynchronous reset at the 4th write of a row
    send_row(3'd1, d_e);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      nxt();
    end
    #1;
    chk("pre_rst_we",   32'(mem_we), 1);
    chk("pre_rst_addr", 32'(mem_addr), 11);
    snap = rd_cnt;
    rst_n = 1'b0;
    #1;
    chk("arst_we",   32'(mem_we), 0);
    chk("arst_busy", 32'(busy), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    nxt();
    repeat (3) nxt();
    @(negedge clk);
    chk("arst_no_done", 32'(rd_cnt), 32'(snap));
    chk("arst_ready",   32'(row_ready), 1);
    chk("arst_partial", 32'(wmem[10]), 32'(d_e[2*PB +: PB]));
    nxt();
    send_row(3'd2, d_b);
    run_row(16, d_b, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
